// File: rtl/sram_1rw1r_param_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM model.
// Holds the sequencer state encoding and the per-lane even-parity function.
package sram_param_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } sram_state_e;

  localparam int unsigned LP_MAX_DATA  = 1024;
  localparam int unsigned LP_MAX_LANES = 128;

  // XOR of each lane_width-bit lane of data; lanes beyond num_wmasks stay 0.
  function automatic logic [LP_MAX_LANES-1:0] lane_parity(
    input logic [LP_MAX_DATA-1:0] data,
    input int unsigned            num_wmasks,
    input int unsigned            lane_width
  );
    logic [LP_MAX_LANES-1:0] par;
    par = '0;
    for (int unsigned i = 0; i < LP_MAX_DATA; i++) begin
      if (i < num_wmasks * lane_width) begin
        par[7'(i / lane_width)] ^= data[10'(i)];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/sram_1rw1r_param_if.sv
// Request/response bundle between a requester (master) and the SRAM model (slave).
interface sram_1rw1r_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int ADDR_WIDTH = 9
);
  logic                  ready;
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dvld0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dvld1;
  logic                  coll1;
  logic                  perr0;
  logic                  perr1;

  modport master (
    input  ready, dout0, dvld0, dout1, dvld1, coll1, perr0, perr1,
    output csb0, web0, wmask0, addr0, din0, csb1, addr1
  );

  modport slave (
    output ready, dout0, dvld0, dout1, dvld1, coll1, perr0, perr1,
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1
  );
endinterface

// File: rtl/sram_1rw1r_param_lane_parity.sv
// Combinational per-lane even-parity generator; only built when SRAM_PARITY_EN is defined,
// since the array carries no parity storage otherwise.
`ifdef SRAM_PARITY_EN
module sram_lane_parity
  import sram_param_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [NUM_WMASKS-1:0] o_par
);
  logic [LP_MAX_LANES-1:0] w_par_all;

  assign w_par_all = lane_parity(LP_MAX_DATA'(i_data), NUM_WMASKS, DATA_WIDTH / NUM_WMASKS);
  assign o_par     = w_par_all[NUM_WMASKS-1:0];
endmodule
`endif

// File: rtl/sram_1rw1r_param.sv
// Parametrised single-clock 1RW+1R SRAM model with post-reset clear, read-valid strobes and
// port1 collision flag. Define SRAM_PARITY_EN to add per-lane parity storage and checking.
module sram_1rw1r_param
  import sram_param_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WMASKS     = 4,
  parameter int ADDR_WIDTH     = 9,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk0,
  input  logic               rstb0,
  sram_1rw1r_param_if.slave  bus
);
  localparam int LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  sram_state_e           r_state;
  sram_state_e           w_next_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  r_ready;

  logic                  r_rd0, r_wr0, r_rd1;
  logic [NUM_WMASKS-1:0] r_wmask0;
  logic [ADDR_WIDTH-1:0] r_addr0, r_addr1;
  logic [DATA_WIDTH-1:0] r_din0;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] w_rd0_word, w_rd1_word, w_bitmask, w_wr_word;

  logic [DATA_WIDTH-1:0] r_dout0, r_dout1;
  logic                  r_dvld0, r_dvld1, r_coll1;

  // Sequencer next state: RESET -> (CLEAR) -> READY.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RESET: begin
        if (CLEAR_ON_RESET != 0) w_next_state = ST_CLEAR;
        else                     w_next_state = ST_READY;
      end
      ST_CLEAR: begin
        if (&r_clr_addr) w_next_state = ST_READY;
        else             w_next_state = ST_CLEAR;
      end
      ST_READY: w_next_state = ST_READY;
      default:  w_next_state = ST_RESET;
    endcase
  end

  // Sequencer state, clear address and registered ready.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      r_state    <= ST_RESET;
      r_clr_addr <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_clr_addr <= (r_state == ST_CLEAR) ? r_clr_addr + 1'b1 : '0;
      r_ready    <= (w_next_state == ST_READY);
    end
  end

  // Request capture; selects are ignored until the sequencer reaches READY.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      r_rd0    <= 1'b0;
      r_wr0    <= 1'b0;
      r_rd1    <= 1'b0;
      r_wmask0 <= '0;
      r_addr0  <= '0;
      r_din0   <= '0;
      r_addr1  <= '0;
    end else begin
      r_rd0    <= r_ready & ~bus.csb0 & bus.web0;
      r_wr0    <= r_ready & ~bus.csb0 & ~bus.web0 & (|bus.wmask0);
      r_rd1    <= r_ready & ~bus.csb1;
      r_wmask0 <= bus.wmask0;
      r_addr0  <= bus.addr0;
      r_din0   <= bus.din0;
      r_addr1  <= bus.addr1;
    end
  end

  for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane_mask
    assign w_bitmask[g*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{r_wmask0[g]}};
  end

  assign w_rd0_word = r_mem[r_addr0];
  assign w_rd1_word = r_mem[r_addr1];
  assign w_wr_word  = (w_rd0_word & ~w_bitmask) | (r_din0 & w_bitmask);

  // Array update: clear sweep has priority, otherwise lane-merged port0 write.
  always_ff @(posedge clk0) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_addr] <= '0;
    end else if (r_wr0) begin
      r_mem[r_addr0] <= w_wr_word;
    end
  end

  // Read data, valid strobes and collision flag; reads see the pre-write word.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      r_dout0 <= '0;
      r_dvld0 <= 1'b0;
      r_dout1 <= '0;
      r_dvld1 <= 1'b0;
      r_coll1 <= 1'b0;
    end else begin
      r_dvld0 <= r_rd0;
      r_dvld1 <= r_rd1;
      r_coll1 <= r_rd1 & r_wr0 & (r_addr0 == r_addr1);
      if (r_rd0) r_dout0 <= w_rd0_word;
      if (r_rd1) r_dout1 <= w_rd1_word;
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] r_mem_par [RAM_DEPTH];
  logic [NUM_WMASKS-1:0] w_par_wr, w_par_rd0, w_par_rd1;
  logic                  r_perr0, r_perr1;

  sram_lane_parity #(.DATA_WIDTH(DATA_WIDTH), .NUM_WMASKS(NUM_WMASKS)) u_par_wr (
    .i_data(r_din0), .o_par(w_par_wr)
  );
  sram_lane_parity #(.DATA_WIDTH(DATA_WIDTH), .NUM_WMASKS(NUM_WMASKS)) u_par_rd0 (
    .i_data(w_rd0_word), .o_par(w_par_rd0)
  );
  sram_lane_parity #(.DATA_WIDTH(DATA_WIDTH), .NUM_WMASKS(NUM_WMASKS)) u_par_rd1 (
    .i_data(w_rd1_word), .o_par(w_par_rd1)
  );

  // Parity bits follow the same lanes as the data they cover.
  always_ff @(posedge clk0) begin
    if (r_state == ST_CLEAR) begin
      r_mem_par[r_clr_addr] <= '0;
    end else if (r_wr0) begin
      r_mem_par[r_addr0] <= (r_mem_par[r_addr0] & ~r_wmask0) | (w_par_wr & r_wmask0);
    end
  end

  // Parity error strobes accompany dvld; data is passed through untouched.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      r_perr0 <= 1'b0;
      r_perr1 <= 1'b0;
    end else begin
      r_perr0 <= r_rd0 & (|(w_par_rd0 ^ r_mem_par[r_addr0]));
      r_perr1 <= r_rd1 & (|(w_par_rd1 ^ r_mem_par[r_addr1]));
    end
  end

  assign bus.perr0 = r_perr0;
  assign bus.perr1 = r_perr1;
`else
  assign bus.perr0 = 1'b0;
  assign bus.perr1 = 1'b0;
`endif

  assign bus.ready = r_ready;
  assign bus.dout0 = r_dout0;
  assign bus.dvld0 = r_dvld0;
  assign bus.dout1 = r_dout1;
  assign bus.dvld1 = r_dvld1;
  assign bus.coll1 = r_coll1;
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed + randomized bench for sram_1rw1r_param against a word-level memory model.
module tb_sram_1rw1r_param;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int AW = 9;
  localparam int RAM_DEPTH = 1 << AW;
  localparam int N_RAND = 300;

  typedef struct packed {
    logic          c0;
    logic          web;
    logic [NW-1:0] m;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          c1;
    logic [AW-1:0] a1;
  } req_t;

  localparam req_t IDLE = '{c0: 1'b1, web: 1'b1, m: 4'h0, a0: 9'h0, d0: 32'h0, c1: 1'b1, a1: 9'h0};

  logic clk0  = 1'b0;
  logic rstb0 = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [DW-1:0] m_mem [RAM_DEPTH];
  logic [DW-1:0] exp_last0, exp_last1;
  logic [AW-1:0] bad_addr = '0;
  logic          bad_valid = 1'b0;
  req_t          p1, p2, cur;

  sram_1rw1r_param_if #(.DATA_WIDTH(DW), .NUM_WMASKS(NW), .ADDR_WIDTH(AW)) bus ();

  sram_1rw1r_param #(.DATA_WIDTH(DW), .NUM_WMASKS(NW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) dut (
    .clk0(clk0), .rstb0(rstb0), .bus(bus)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic c0, input logic web, input logic [NW-1:0] m,
                              input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic c1, input logic [AW-1:0] a1);
    req_t r;
    r.c0 = c0; r.web = web; r.m = m; r.a0 = a0; r.d0 = d0; r.c1 = c1; r.a1 = a1;
    return r;
  endfunction

  task automatic drive(input req_t r);
    bus.csb0 = r.c0; bus.web0 = r.web; bus.wmask0 = r.m; bus.addr0 = r.a0;
    bus.din0 = r.d0; bus.csb1 = r.c1; bus.addr1 = r.a1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
    chk({tag, "_dout0"}, bus.dout0, 32'd0);
    chk({tag, "_dout1"}, bus.dout1, 32'd0);
    chk({tag, "_dvld0"}, 32'(bus.dvld0), 32'd0);
    chk({tag, "_dvld1"}, 32'(bus.dvld1), 32'd0);
    chk({tag, "_coll1"}, 32'(bus.coll1), 32'd0);
    chk({tag, "_perr0"}, 32'(bus.perr0), 32'd0);
    chk({tag, "_perr1"}, 32'(bus.perr1), 32'd0);
  endtask

  // Compare outputs with what request r (issued two negedges ago) must produce, then apply it.
  task automatic eval(input req_t r);
    logic          rd0, rd1, coll, pe1;
    logic [DW-1:0] w;
    rd0  = !r.c0 && r.web;
    rd1  = !r.c1;
    coll = rd1 && !r.c0 && !r.web && (r.m != 4'h0) && (r.a0 == r.a1);
    pe1  = rd1 && bad_valid && (r.a1 == bad_addr);
    if (rd0) exp_last0 = m_mem[r.a0];
    if (rd1) exp_last1 = m_mem[r.a1];
    chk("dvld0", 32'(bus.dvld0), 32'(rd0));
    chk("dvld1", 32'(bus.dvld1), 32'(rd1));
    chk("coll1", 32'(bus.coll1), 32'(coll));
    chk("dout0", bus.dout0, exp_last0);
    chk("dout1", bus.dout1, exp_last1);
    chk("perr0", 32'(bus.perr0), 32'(rd0 && bad_valid && (r.a0 == bad_addr)));
    chk("perr1", 32'(bus.perr1), 32'(pe1));
    if (!r.c0 && !r.web) begin
      w = m_mem[r.a0];
      for (int l = 0; l < NW; l++) begin
        if (r.m[l]) w[8*l +: 8] = r.d0[8*l +: 8];
      end
      m_mem[r.a0] = w;
    end
  endtask

  task automatic cycle(input req_t c);
    @(negedge clk0);
    eval(p2);
    drive(c);
    p2 = p1;
    p1 = c;
  endtask

  // Count edges from reset release to ready, watching for stray read strobes.
  task automatic wait_ready(input string tag);
    int   cyc;
    logic saw;
    cyc = 0;
    saw = 1'b0;
    while (bus.ready !== 1'b1 && cyc < 2000) begin
      @(posedge clk0);
      #1;
      cyc++;
      if (bus.dvld0 === 1'b1 || bus.dvld1 === 1'b1) saw = 1'b1;
    end
    drive(IDLE);
    chk({tag, "_ready_cycles"}, 32'(cyc), 32'(RAM_DEPTH + 1));
    chk({tag, "_busy_dvld"}, 32'(saw), 32'd0);
    for (int i = 0; i < RAM_DEPTH; i++) m_mem[i] = '0;
    p1 = IDLE;
    p2 = IDLE;
    exp_last0 = '0;
    exp_last1 = '0;
  endtask

  initial begin
    drive(IDLE);
    p1 = IDLE;
    p2 = IDLE;
    #1 rstb0 = 1'b0;
    #2 chk_zero("reset");

    // Release with a write/read pending while busy: must be ignored.
    @(negedge clk0);
    rstb0 = 1'b1;
    drive(mk(1'b0, 1'b0, 4'hF, 9'h030, 32'hDEADBEEF, 1'b0, 9'h030));
    wait_ready("init");

    cycle(mk(1'b0, 1'b1, 4'h0, 9'h030, 32'h0, 1'b0, 9'h1FF));
    cycle(IDLE);
    cycle(IDLE);
    chk("busy_no_write", bus.dout0, 32'h0);
    chk("clear_1ff", bus.dout1, 32'h0);

    // Masked write merge and read latency.
    cycle(mk(1'b0, 1'b0, 4'hF, 9'h010, 32'hAABBCCDD, 1'b1, 9'h0));
    cycle(mk(1'b0, 1'b0, 4'h5, 9'h010, 32'h11223344, 1'b1, 9'h0));
    cycle(mk(1'b0, 1'b1, 4'h0, 9'h010, 32'h0, 1'b1, 9'h0));
    cycle(IDLE);
    chk("mw_dvld_edge1", 32'(bus.dvld0), 32'd0);
    cycle(IDLE);
    chk("mw_dvld_edge2", 32'(bus.dvld0), 32'd1);
    chk("mw_data", bus.dout0, 32'hAA22CC44);
    cycle(IDLE);
    chk("mw_dvld_pulse", 32'(bus.dvld0), 32'd0);

    // Both ports reading one address.
    cycle(mk(1'b0, 1'b1, 4'h0, 9'h010, 32'h0, 1'b0, 9'h010));
    cycle(IDLE);
    cycle(IDLE);
    chk("dual_rd_match", bus.dout1, 32'hAA22CC44);

    // Collision returns the old word.
    cycle(mk(1'b0, 1'b0, 4'hF, 9'h020, 32'hFFFFFFFF, 1'b0, 9'h020));
    cycle(mk(1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 9'h020));
    cycle(IDLE);
    chk("coll_old_data", bus.dout1, 32'h0);
    chk("coll_flag", 32'(bus.coll1), 32'd1);
    cycle(IDLE);
    chk("coll_new_data", bus.dout1, 32'hFFFFFFFF);
    chk("coll_cleared", 32'(bus.coll1), 32'd0);

    // Randomized traffic over a small window to provoke collisions.
    for (int k = 0; k < N_RAND; k++) begin
      cur.c0  = ($urandom_range(0, 3) == 0);
      cur.web = 1'($urandom_range(0, 1));
      cur.m   = 4'($urandom_range(0, 15));
      cur.a0  = 9'h100 + 9'($urandom_range(0, 7));
      cur.d0  = $urandom;
      cur.c1  = ($urandom_range(0, 2) == 0);
      cur.a1  = 9'h100 + 9'($urandom_range(0, 7));
      cycle(cur);
    end
    cycle(IDLE);
    cycle(IDLE);

    // Async reset, then reset again mid-clear at address 100.
    @(negedge clk0);
    rstb0 = 1'b0;
    drive(IDLE);
    #1 chk_zero("rst_async");
    @(negedge clk0);
    rstb0 = 1'b1;
    repeat (101) @(posedge clk0);
    #1 rstb0 = 1'b0;
    #1 chk_zero("rst_midclear");
    @(negedge clk0);
    rstb0 = 1'b1;
    wait_ready("reclear");

    cycle(mk(1'b0, 1'b1, 4'h0, 9'h100, 32'h0, 1'b0, 9'h010));
    cycle(IDLE);
    cycle(IDLE);
    chk("post_clear_dvld", 32'(bus.dvld0), 32'd1);
    chk("post_clear_010", bus.dout1, 32'h0);

    // Parity: corrupt a lane-1 bit of a stored word, then read it on port1.
    cycle(mk(1'b0, 1'b0, 4'hF, 9'h040, 32'h12345678, 1'b1, 9'h0));
    cycle(IDLE);
    cycle(IDLE);
`ifdef SRAM_PARITY_EN
    dut.r_mem[9'h040] = 32'h12345778;
    m_mem[9'h040] = 32'h12345778;
    bad_addr  = 9'h040;
    bad_valid = 1'b1;
`endif
    cycle(mk(1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 9'h040));
    cycle(IDLE);
    cycle(IDLE);
`ifdef SRAM_PARITY_EN
    chk("par_perr1", 32'(bus.perr1), 32'd1);
    chk("par_data", bus.dout1, 32'h12345778);
`else
    chk("par_perr1", 32'(bus.perr1), 32'd0);
    chk("par_data", bus.dout1, 32'h12345678);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
